// File: rtl/timer_clint.sv
// CLINT-style machine timer on the data bus: 64-bit mtime with prescaler,
// 64-bit mtimecmp, and a registered level-sensitive timer interrupt.
module timer_clint #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter logic [15:0] PRESC_RST = 16'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        I_req,
  input  logic        I_we,
  input  logic [31:0] I_addr,
  input  logic [31:0] I_wdata,
  input  logic [3:0]  I_mask,
  output logic [31:0] O_rdata,
  output logic        O_sel,
  output logic        O_timer_int
);

  typedef enum logic [5:0] {
    REG_CTRL     = 6'd0,
    REG_PRESC    = 6'd1,
    REG_MTIME_LO = 6'd2,
    REG_MTIME_HI = 6'd3,
    REG_CMP_LO   = 6'd4,
    REG_CMP_HI   = 6'd5,
    REG_STATUS   = 6'd6
  } reg_idx_e;

  logic [1:0]  ctrl_q,      ctrl_d;
  logic [15:0] presc_q,     presc_d;
  logic [15:0] pcnt_q,      pcnt_d;
  logic [63:0] mtime_q,     mtime_d;
  logic [63:0] mtimecmp_q,  mtimecmp_d;
  logic        timer_int_q, timer_int_d;

  logic        sel;
  logic        wr;
  logic [5:0]  off;
  logic [31:0] wmask;
  logic        tick;
  logic        time_ge;
  logic        unused_addr;

  assign sel         = I_req && (I_addr[31:8] == BASE_ADDR[31:8]);
  assign wr          = sel && I_we;
  assign off         = I_addr[7:2];
  assign time_ge     = (mtime_q >= mtimecmp_q);
  assign unused_addr = ^I_addr[1:0];

  always_comb begin
    wmask = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      wmask[i*8 +: 8] = {8{I_mask[i]}};
    end
  end

  always_comb begin
    ctrl_d      = ctrl_q;
    presc_d     = presc_q;
    pcnt_d      = pcnt_q;
    mtime_d     = mtime_q;
    mtimecmp_d  = mtimecmp_q;
    tick        = 1'b0;
    timer_int_d = ctrl_q[1] && time_ge;

    if (ctrl_q[0]) begin
      if (pcnt_q == presc_q) begin
        pcnt_d = '0;
        tick   = 1'b1;
      end else begin
        pcnt_d = pcnt_q + 16'd1;
      end
    end

    if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    // A write to either mtime half replaces the whole 64-bit value, so any
    // increment computed above for this cycle is discarded.
    if (wr) begin
      case (off)
        REG_CTRL: begin
          ctrl_d = (ctrl_q & ~wmask[1:0]) | (I_wdata[1:0] & wmask[1:0]);
          if (!ctrl_d[0]) pcnt_d = '0;
        end
        REG_PRESC: begin
          presc_d = (presc_q & ~wmask[15:0]) | (I_wdata[15:0] & wmask[15:0]);
          pcnt_d  = '0;
        end
        REG_MTIME_LO: mtime_d = {mtime_q[63:32],
                                 (mtime_q[31:0] & ~wmask) | (I_wdata & wmask)};
        REG_MTIME_HI: mtime_d = {(mtime_q[63:32] & ~wmask) | (I_wdata & wmask),
                                 mtime_q[31:0]};
        REG_CMP_LO:   mtimecmp_d = {mtimecmp_q[63:32],
                                    (mtimecmp_q[31:0] & ~wmask) | (I_wdata & wmask)};
        REG_CMP_HI:   mtimecmp_d = {(mtimecmp_q[63:32] & ~wmask) | (I_wdata & wmask),
                                    mtimecmp_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q      <= '0;
      presc_q     <= PRESC_RST;
      pcnt_q      <= '0;
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      timer_int_q <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      presc_q     <= presc_d;
      pcnt_q      <= pcnt_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      timer_int_q <= timer_int_d;
    end
  end

  always_comb begin
    O_rdata = '0;
    if (sel) begin
      case (off)
        REG_CTRL:     O_rdata = {30'd0, ctrl_q};
        REG_PRESC:    O_rdata = {16'd0, presc_q};
        REG_MTIME_LO: O_rdata = mtime_q[31:0];
        REG_MTIME_HI: O_rdata = mtime_q[63:32];
        REG_CMP_LO:   O_rdata = mtimecmp_q[31:0];
        REG_CMP_HI:   O_rdata = mtimecmp_q[63:32];
        REG_STATUS:   O_rdata = {31'd0, time_ge};
        default:      O_rdata = '0;
      endcase
    end
  end

  assign O_sel       = sel;
  assign O_timer_int = timer_int_q;

endmodule

// File: tb/tb_timer_clint.sv
// Self-checking bench for timer_clint: expected read data is queued when a
// bus read is issued and popped/compared when the data is sampled.
module tb_timer_clint;

  localparam logic [31:0] BASE   = 32'h0200_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_PRSC = BASE + 32'h04;
  localparam logic [31:0] A_MTLO = BASE + 32'h08;
  localparam logic [31:0] A_MTHI = BASE + 32'h0C;
  localparam logic [31:0] A_CMLO = BASE + 32'h10;
  localparam logic [31:0] A_CMHI = BASE + 32'h14;
  localparam logic [31:0] A_STAT = BASE + 32'h18;

  logic        clk = 1'b0;
  logic        rst;
  logic        I_req, I_we;
  logic [31:0] I_addr, I_wdata;
  logic [3:0]  I_mask;
  logic [31:0] O_rdata;
  logic        O_sel, O_timer_int;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  string       sb_tag[$];
  logic [31:0] sb_exp[$];

  timer_clint #(.BASE_ADDR(BASE), .PRESC_RST(16'd0)) dut (
    .clk         (clk),
    .rst         (rst),
    .I_req       (I_req),
    .I_we        (I_we),
    .I_addr      (I_addr),
    .I_wdata     (I_wdata),
    .I_mask      (I_mask),
    .O_rdata     (O_rdata),
    .O_sel       (O_sel),
    .O_timer_int (O_timer_int)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] mask);
    @(negedge clk);
    I_req = 1'b1; I_we = 1'b1; I_addr = addr; I_wdata = data; I_mask = mask;
    @(posedge clk);
    #1;
    I_req = 1'b0; I_we = 1'b0; I_mask = 4'h0;
  endtask

  task automatic bus_read(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp);
    string       t;
    logic [31:0] e;
    sb_tag.push_back(tag);
    sb_exp.push_back(exp);
    @(negedge clk);
    I_req = 1'b1; I_we = 1'b0; I_addr = addr;
    #1;
    t = sb_tag.pop_front();
    e = sb_exp.pop_front();
    check(t, O_rdata, e);
    I_req = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; I_req = 1'b0; I_we = 1'b0;
    I_addr = '0; I_wdata = '0; I_mask = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Reset state
    check("rst_int", {31'd0, O_timer_int}, 32'd0);
    bus_read("rst_ctrl", A_CTRL, 32'd0);
    bus_read("rst_presc", A_PRSC, 32'd0);
    bus_read("rst_mtlo", A_MTLO, 32'd0);
    bus_read("rst_mthi", A_MTHI, 32'd0);
    bus_read("rst_cmlo", A_CMLO, 32'hFFFF_FFFF);
    bus_read("rst_cmhi", A_CMHI, 32'hFFFF_FFFF);
    bus_read("rst_off20", BASE + 32'h20, 32'd0);
    bus_read("out_of_win", 32'h0300_0008, 32'd0);
    @(negedge clk);
    I_req = 1'b1; I_addr = 32'h0300_0008; #1;
    check("sel_outside", {31'd0, O_sel}, 32'd0);
    I_addr = A_STAT; #1;
    check("sel_inside", {31'd0, O_sel}, 32'd1);
    I_req = 1'b0; #1;
    check("sel_noreq", {31'd0, O_sel}, 32'd0);

    // PRESC=0: one tick per cycle, 10 after 10 edges, then freeze
    bus_write(A_PRSC, 32'd0, 4'hF);
    bus_write(A_CTRL, 32'h0000_00FD, 4'hF);
    bus_read("ctrl_rsvd", A_CTRL, 32'd1);
    bus_write(A_CTRL, 32'd0, 4'hF);
    bus_write(A_MTLO, 32'd0, 4'hF);
    bus_write(A_CTRL, 32'd1, 4'hF);
    repeat (10) @(posedge clk);
    bus_read("p0_ten", A_MTLO, 32'd10);
    bus_write(A_CTRL, 32'd0, 4'hF);
    repeat (5) @(posedge clk);
    bus_read("p0_frozen", A_MTLO, 32'd12);
    bus_read("p0_frozen_byte_addr", A_MTLO + 32'd3, 32'd12);

    // PRESC=3: one tick every 4 cycles; PRESC write restarts phase
    bus_write(A_MTLO, 32'd0, 4'hF);
    bus_write(A_PRSC, 32'd3, 4'hF);
    bus_write(A_CTRL, 32'd1, 4'hF);
    repeat (8) @(posedge clk);
    bus_read("p3_two", A_MTLO, 32'd2);
    repeat (2) @(posedge clk);
    bus_write(A_PRSC, 32'd3, 4'hF);
    repeat (3) @(posedge clk);
    bus_read("p3_restart_hold", A_MTLO, 32'd2);
    bus_read("p3_restart_tick", A_MTLO, 32'd3);
    bus_write(A_PRSC, 32'h1234_5678, 4'b0000);
    bus_read("presc_mask0", A_PRSC, 32'd3);

    // 64-bit carry and full wrap
    bus_write(A_CTRL, 32'd0, 4'hF);
    bus_write(A_PRSC, 32'd0, 4'hF);
    bus_write(A_MTHI, 32'd0, 4'hF);
    bus_write(A_MTLO, 32'hFFFF_FFFE, 4'hF);
    bus_write(A_CTRL, 32'd1, 4'hF);
    repeat (2) @(posedge clk);
    bus_read("carry_lo", A_MTLO, 32'd0);
    bus_read("carry_hi", A_MTHI, 32'd1);
    bus_write(A_CTRL, 32'd0, 4'hF);
    bus_write(A_MTHI, 32'hFFFF_FFFF, 4'hF);
    bus_write(A_MTLO, 32'hFFFF_FFFF, 4'hF);
    bus_write(A_CTRL, 32'd1, 4'hF);
    @(posedge clk);
    bus_read("wrap_lo", A_MTLO, 32'd0);
    bus_read("wrap_hi", A_MTHI, 32'd0);

    // Interrupt against mtimecmp=20
    bus_write(A_CTRL, 32'd0, 4'hF);
    bus_write(A_MTHI, 32'd0, 4'hF);
    bus_write(A_MTLO, 32'd0, 4'hF);
    bus_write(A_CMHI, 32'd0, 4'hF);
    bus_write(A_CMLO, 32'd20, 4'hF);
    bus_write(A_CTRL, 32'd3, 4'hF);
    repeat (20) @(posedge clk);
    bus_read("irq_mt20", A_MTLO, 32'd20);
    check("irq_not_yet", {31'd0, O_timer_int}, 32'd0);
    @(posedge clk);
    bus_read("irq_status", A_STAT, 32'd1);
    check("irq_rise", {31'd0, O_timer_int}, 32'd1);
    bus_write(A_CMLO, 32'd100, 4'hF);
    check("irq_hold_edge", {31'd0, O_timer_int}, 32'd1);
    @(posedge clk); #1;
    check("irq_fall", {31'd0, O_timer_int}, 32'd0);
    bus_write(A_CMLO, 32'd0, 4'hF);
    @(posedge clk); #1;
    check("irq_cmp0", {31'd0, O_timer_int}, 32'd1);
    bus_write(A_CTRL, 32'd1, 4'hF);
    @(posedge clk); #1;
    check("irq_ie_off", {31'd0, O_timer_int}, 32'd0);
    repeat (3) @(posedge clk);
    bus_read("status_ie_off", A_STAT, 32'd1);
    check("irq_stays_low", {31'd0, O_timer_int}, 32'd0);

    // Byte-masked mtime write on a tick cycle
    bus_write(A_CTRL, 32'd0, 4'hF);
    bus_write(A_MTHI, 32'd0, 4'hF);
    bus_write(A_MTLO, 32'h1234_5600, 4'hF);
    bus_write(A_CTRL, 32'd1, 4'hF);
    bus_write(A_MTLO, 32'hAAAA_AA05, 4'b0001);
    bus_read("mask_wins", A_MTLO, 32'h1234_5605);
    bus_read("mask_next", A_MTLO, 32'h1234_5606);
    bus_read("mask_hi", A_MTHI, 32'd0);

    // Asynchronous reset mid-count
    bus_write(A_CMLO, 32'd0, 4'hF);
    bus_write(A_CTRL, 32'd3, 4'hF);
    @(posedge clk); #1;
    check("pre_rst_int", {31'd0, O_timer_int}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rst_async_int", {31'd0, O_timer_int}, 32'd0);
    I_req = 1'b1; I_addr = A_MTLO; #1;
    check("rst_async_mt", O_rdata, 32'd0);
    I_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus_read("post_rst_ctrl", A_CTRL, 32'd0);
    bus_read("post_rst_mtlo", A_MTLO, 32'd0);
    bus_read("post_rst_cmlo", A_CMLO, 32'hFFFF_FFFF);
    bus_read("post_rst_status", A_STAT, 32'd0);
    check("post_rst_int", {31'd0, O_timer_int}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
